fwd_hazard_unit: RTL and testbench

Operand-forwarding and load-use hazard unit for the 5-stage MIPS pipeline. It sits directly upstream of the two 3:1 operand muxes at the ALU input and drives their 2-bit selects. It tracks the destination registers of the instructions in EX and MEM, and registers one select pair per instruction as that instruction advances from ID to EX. It stalls ID for one cycle on a load-use dependency and counts stalls for the testbench.

---
 rtl/fwd_hazard_unit_if.sv | 32 +++
 rtl/fwd_hazard_unit.sv | 125 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if
// Bundles the ID-stage instruction fields presented to the forwarding/hazard
// unit with the forwarding selects, stall and stall counter it returns.
//   master : the pipeline side; drives the ID fields and observes the results
//   slave  : the forwarding/hazard unit itself
// Signals:
//   id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read  (master -> slave)
//   fwd_a_sel, fwd_b_sel, stall, stall_count                    (slave -> master)
interface fwd_hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Operand-forwarding and load-use hazard unit for a 5-stage MIPS pipeline.
// Tracks the destination registers of the instructions in EX and MEM,
// registers a pair of ALU operand-mux selects as each instruction moves from
// ID to EX, stalls ID for one cycle on a load-use dependency and keeps a
// saturating count of stall cycles.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : fwd_hazard_unit_if.slave
//            in : id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read
//            out: fwd_a_sel / fwd_b_sel (00 regfile, 01 EX/MEM, 10 MEM/WB),
//                 stall (combinational), stall_count (saturating)
module fwd_hazard_unit #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  fwd_hazard_unit_if.slave  bus
);

  logic             ex_valid_q, ex_valid_d;
  logic [4:0]       ex_dest_q, ex_dest_d;
  logic             ex_wr_q, ex_wr_d;
  logic             ex_load_q, ex_load_d;
  logic             mem_valid_q, mem_valid_d;
  logic [4:0]       mem_dest_q, mem_dest_d;
  logic             mem_wr_q, mem_wr_d;
  logic [1:0]       a_sel_q, a_sel_d;
  logic [1:0]       b_sel_q, b_sel_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             stall;
  logic             advance;

  // Select for one source operand. The EX producer is checked first so the
  // youngest writer of a register wins; $0 is hardwired and never forwarded.
  function automatic logic [1:0] sel_for(
    input logic [4:0] src,
    input logic       exv,
    input logic       exw,
    input logic [4:0] exd,
    input logic       memv,
    input logic       memw,
    input logic [4:0] memd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (exv && exw && exd == src)
        sel = 2'b01;
      else if (memv && memw && memd == src)
        sel = 2'b10;
    end
    return sel;
  endfunction

  // Stall only when the load in EX really writes a register the ID
  // instruction reads. Built purely from state and ID inputs, so an
  // asynchronous reset clearing ex_valid drops it immediately.
  always_comb begin
    stall = bus.id_valid && ex_valid_q && ex_load_q && ex_wr_q &&
            (ex_dest_q != 5'd0) &&
            (ex_dest_q == bus.id_rs || ex_dest_q == bus.id_rt);
    advance = bus.id_valid && !stall;

    mem_valid_d = ex_valid_q;
    mem_dest_d  = ex_dest_q;
    mem_wr_d    = ex_wr_q;

    // A stalled or empty ID slot enters EX as a bubble.
    ex_valid_d = advance;
    ex_dest_d  = advance ? bus.id_dest : 5'd0;
    ex_wr_d    = advance && bus.id_reg_write;
    ex_load_d  = advance && bus.id_mem_read;

    // Selects are only meaningful for an advancing instruction; a bubble
    // needs no forwarding. Gating on advance also covers the stall case,
    // after which the load sits in MEM and resolves to 10.
    a_sel_d = 2'b00;
    b_sel_d = 2'b00;
    if (advance) begin
      a_sel_d = sel_for(bus.id_rs, ex_valid_q, ex_wr_q, ex_dest_q,
                        mem_valid_q, mem_wr_q, mem_dest_q);
      b_sel_d = sel_for(bus.id_rt, ex_valid_q, ex_wr_q, ex_dest_q,
                        mem_valid_q, mem_wr_q, mem_dest_q);
    end

    // Saturate at all-ones rather than wrap.
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != {CNT_W{1'b1}})
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_dest_q     <= 5'd0;
      ex_wr_q       <= 1'b0;
      ex_load_q     <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_dest_q    <= 5'd0;
      mem_wr_q      <= 1'b0;
      a_sel_q       <= 2'b00;
      b_sel_q       <= 2'b00;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_dest_q     <= ex_dest_d;
      ex_wr_q       <= ex_wr_d;
      ex_load_q     <= ex_load_d;
      mem_valid_q   <= mem_valid_d;
      mem_dest_q    <= mem_dest_d;
      mem_wr_q      <= mem_wr_d;
      a_sel_q       <= a_sel_d;
      b_sel_q       <= b_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.fwd_a_sel   = a_sel_q;
  assign bus.fwd_b_sel   = b_sel_q;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
// Self-checking bench for fwd_hazard_unit. Directed scenarios for each
// forwarding/hazard feature plus a randomized run checked against a model
// that keeps the recently issued instructions in a queue and applies the
// forwarding and load-use rules to it directly. A narrow counter width keeps
// the saturation scenario short.
module tb_fwd_hazard_unit;

  localparam int TB_CNT_W = 4;
  localparam int SAT      = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.CNT_W(TB_CNT_W)) bus ();

  fwd_hazard_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit v;
    int dest;
    bit wr;
    bit ld;
  } instr_t;

  // Issue history: last entry is the instruction now in EX, the one before
  // it is in MEM. Bubbles are entries with v = 0.
  instr_t hist[$];
  int     model_count;
  int     total = 0;
  int     bad   = 0;

  bit                  exp_stall;
  int                  exp_a, exp_b;
  logic                obs_stall;
  logic [1:0]          obs_a, obs_b;
  logic [TB_CNT_W-1:0] obs_cnt;

  function automatic instr_t bubble();
    instr_t b;
    b = '{1'b0, 0, 1'b0, 1'b0};
    return b;
  endfunction

  function automatic void model_reset();
    hist.delete();
    hist.push_back(bubble());
    hist.push_back(bubble());
    model_count = 0;
  endfunction

  function automatic bit writes_reg(instr_t s, int r);
    return s.v && s.wr && s.dest == r;
  endfunction

  function automatic int model_sel(int src);
    if (src == 0) return 0;
    if (writes_reg(hist[$], src)) return 1;
    if (writes_reg(hist[$-1], src)) return 2;
    return 0;
  endfunction

  function automatic bit model_stall(bit v, int rs, int rt);
    instr_t ex;
    ex = hist[$];
    return v && ex.v && ex.ld && ex.wr && ex.dest != 0 &&
           (ex.dest == rs || ex.dest == rt);
  endfunction

  // Presents one ID instruction for one clock: samples stall before the edge,
  // advances the model, and samples the registered outputs after the edge.
  task automatic drive_cycle(input bit v, input int rs, input int rt,
                             input int dest, input bit wr, input bit ld);
    instr_t nxt;
    bus.id_valid     = v;
    bus.id_rs        = rs[4:0];
    bus.id_rt        = rt[4:0];
    bus.id_dest      = dest[4:0];
    bus.id_reg_write = wr;
    bus.id_mem_read  = ld;
    #1;
    obs_stall = bus.stall;
    exp_stall = model_stall(v, rs, rt);
    if (v && !exp_stall) begin
      exp_a = model_sel(rs);
      exp_b = model_sel(rt);
      nxt   = '{1'b1, dest, wr, ld};
    end else begin
      exp_a = 0;
      exp_b = 0;
      nxt   = bubble();
    end
    if (exp_stall && model_count < SAT) model_count++;
    hist.push_back(nxt);
    if (hist.size() > 2) void'(hist.pop_front());
    @(posedge clk);
    #1;
    obs_a   = bus.fwd_a_sel;
    obs_b   = bus.fwd_b_sel;
    obs_cnt = bus.stall_count;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd1;
    bus.id_dest = 5'd2; bus.id_reg_write = 1'b1; bus.id_mem_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.fwd_a_sel !== 2'b00) begin bad++; $display("[TB] FAIL reset_a_sel got=%0d want=0", bus.fwd_a_sel); end
    total++; if (bus.fwd_b_sel !== 2'b00) begin bad++; $display("[TB] FAIL reset_b_sel got=%0d want=0", bus.fwd_b_sel); end
    total++; if (bus.stall_count !== '0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", bus.stall_count); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%0d want=0", bus.stall); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_ex_forward();
    drive_cycle(1, 1, 2, 3, 1, 0);
    drive_cycle(1, 3, 5, 4, 1, 0);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL exfwd_stall got=%0d want=0", obs_stall); end
    total++; if (obs_a !== 2'b01) begin bad++; $display("[TB] FAIL exfwd_a got=%0d want=1", obs_a); end
    total++; if (obs_b !== 2'b00) begin bad++; $display("[TB] FAIL exfwd_b got=%0d want=0", obs_b); end
  endtask

  task automatic test_mem_forward();
    drive_cycle(1, 1, 2, 3, 1, 0);
    drive_cycle(1, 11, 12, 10, 1, 0);
    drive_cycle(1, 7, 3, 6, 1, 0);
    total++; if (obs_a !== 2'b00) begin bad++; $display("[TB] FAIL memfwd_a got=%0d want=0", obs_a); end
    total++; if (obs_b !== 2'b10) begin bad++; $display("[TB] FAIL memfwd_b got=%0d want=2", obs_b); end
  endtask

  task automatic test_load_use();
    drive_cycle(1, 1, 0, 8, 1, 1);
    drive_cycle(1, 8, 8, 9, 1, 0);
    total++; if (obs_stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%0d want=1", obs_stall); end
    total++; if (obs_a !== 2'b00) begin bad++; $display("[TB] FAIL lu_bubble_a got=%0d want=0", obs_a); end
    total++; if (obs_b !== 2'b00) begin bad++; $display("[TB] FAIL lu_bubble_b got=%0d want=0", obs_b); end
    drive_cycle(1, 8, 8, 9, 1, 0);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_restall got=%0d want=0", obs_stall); end
    total++; if (obs_a !== 2'b10) begin bad++; $display("[TB] FAIL lu_a got=%0d want=2", obs_a); end
    total++; if (obs_b !== 2'b10) begin bad++; $display("[TB] FAIL lu_b got=%0d want=2", obs_b); end
    total++; if (obs_cnt !== TB_CNT_W'(1)) begin bad++; $display("[TB] FAIL lu_count got=%0d want=1", obs_cnt); end
  endtask

  task automatic test_zero_reg();
    drive_cycle(1, 1, 2, 0, 1, 0);
    drive_cycle(1, 1, 0, 0, 1, 1);
    drive_cycle(1, 0, 0, 5, 1, 0);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL zero_stall got=%0d want=0", obs_stall); end
    total++; if (obs_a !== 2'b00) begin bad++; $display("[TB] FAIL zero_a got=%0d want=0", obs_a); end
    total++; if (obs_b !== 2'b00) begin bad++; $display("[TB] FAIL zero_b got=%0d want=0", obs_b); end
  endtask

  task automatic test_youngest();
    drive_cycle(1, 1, 2, 3, 1, 0);
    drive_cycle(1, 4, 5, 3, 1, 0);
    drive_cycle(1, 3, 3, 7, 1, 0);
    total++; if (obs_a !== 2'b01) begin bad++; $display("[TB] FAIL young_a got=%0d want=1", obs_a); end
    total++; if (obs_b !== 2'b01) begin bad++; $display("[TB] FAIL young_b got=%0d want=1", obs_b); end
  endtask

  task automatic test_random();
    int v, rs, rt, dest, wr, ld;
    v = 1; rs = 1; rt = 2; dest = 3; wr = 1; ld = 0;
    for (int i = 0; i < 400; i++) begin
      // A stalled instruction stays in ID until it can advance.
      if (!(i > 0 && exp_stall)) begin
        v    = ($urandom_range(0, 7) != 0);
        rs   = $urandom_range(0, 3);
        rt   = $urandom_range(0, 3);
        dest = $urandom_range(0, 3);
        wr   = $urandom_range(0, 3) != 0;
        ld   = $urandom_range(0, 2) == 0;
      end
      drive_cycle(v[0], rs, rt, dest, wr[0], ld[0]);
      total++; if (obs_stall !== exp_stall) begin bad++; $display("[TB] FAIL rnd_stall i=%0d got=%0d want=%0d", i, obs_stall, exp_stall); end
      total++; if (obs_a !== 2'(exp_a)) begin bad++; $display("[TB] FAIL rnd_a i=%0d got=%0d want=%0d", i, obs_a, exp_a); end
      total++; if (obs_b !== 2'(exp_b)) begin bad++; $display("[TB] FAIL rnd_b i=%0d got=%0d want=%0d", i, obs_b, exp_b); end
      total++; if (obs_cnt !== TB_CNT_W'(model_count)) begin bad++; $display("[TB] FAIL rnd_count i=%0d got=%0d want=%0d", i, obs_cnt, model_count); end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(1, 1, 0, 8, 1, 1);
    bus.id_valid = 1'b1; bus.id_rs = 5'd8; bus.id_rt = 5'd8;
    bus.id_dest = 5'd9; bus.id_reg_write = 1'b1; bus.id_mem_read = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_stall got=%0d want=1", bus.stall); end
    reset = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL mid_async_stall got=%0d want=0", bus.stall); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    total++; if (bus.fwd_a_sel !== 2'b00) begin bad++; $display("[TB] FAIL mid_a got=%0d want=0", bus.fwd_a_sel); end
    total++; if (bus.fwd_b_sel !== 2'b00) begin bad++; $display("[TB] FAIL mid_b got=%0d want=0", bus.fwd_b_sel); end
    total++; if (bus.stall_count !== '0) begin bad++; $display("[TB] FAIL mid_count got=%0d want=0", bus.stall_count); end
    drive_cycle(1, 8, 8, 9, 1, 0);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL mid_first_stall got=%0d want=0", obs_stall); end
    total++; if (obs_a !== 2'b00) begin bad++; $display("[TB] FAIL mid_first_a got=%0d want=0", obs_a); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < SAT + 1 + 5; i++) begin
      drive_cycle(1, 1, 0, 8, 1, 1);
      drive_cycle(1, 8, 8, 9, 1, 0);
      total++; if (obs_stall !== 1'b1) begin bad++; $display("[TB] FAIL sat_stall i=%0d got=%0d want=1", i, obs_stall); end
      total++; if (obs_cnt !== TB_CNT_W'(model_count)) begin bad++; $display("[TB] FAIL sat_count i=%0d got=%0d want=%0d", i, obs_cnt, model_count); end
      drive_cycle(1, 8, 8, 9, 1, 0);
    end
    total++; if (obs_cnt !== TB_CNT_W'(SAT)) begin bad++; $display("[TB] FAIL sat_final got=%0d want=%0d", obs_cnt, SAT); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_zero_reg();
    test_youngest();
    test_random();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
